// File: rtl/mul_product_collector_if.sv
// Handshake bundle between the shift-add multiplier stream and the collector.
// Carries start/serial_in/ready in, and product/valid/busy back out.
`timescale 1ns/1ps

interface mul_product_collector_if #(
    parameter int n = 32
);
    logic             start;
    logic             serial_in;
    logic             ready;
    logic [2*n-1:0]   product;
    logic             valid;
    logic             busy;

    modport master (
        output start,
        output serial_in,
        output ready,
        input  product,
        input  valid,
        input  busy
    );

    modport slave (
        input  start,
        input  serial_in,
        input  ready,
        output product,
        output valid,
        output busy
    );
endinterface

// File: rtl/mul_product_collector.sv
// Collects the multiplier's LSB-first product bit stream into a 2n-bit word.
// Ports: clk, rst (sync, active-high), bus (slave: start/serial_in/ready in,
// product/valid/busy out).
`timescale 1ns/1ps

module mul_product_collector #(
    parameter int n   = 32,
    parameter int LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    mul_product_collector_if.slave bus
);
    localparam int W  = 2 * n;
    localparam int CB = $clog2(W + 1);
    // The shared counter must also reach LAT-1 (up to 14) while skipping,
    // so it never shrinks below 4 bits for very narrow operands.
    localparam int CW = (CB > 4) ? CB : 4;

    if (LAT < 0 || LAT > 15) begin : g_lat_chk
        $error("LAT out of range 0..15");
    end

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        SHIFT,
        DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_product;
    logic            r_valid;
    logic            r_busy;

    assign bus.product = r_product;
    assign bus.valid   = r_valid;
    assign bus.busy    = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_product <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else if (bus.start) begin
            // A start restarts from any state and beats a pending accept.
            r_state   <= (LAT == 0) ? SHIFT : SKIP;
            r_cnt     <= '0;
            r_product <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_state <= IDLE;
                end
                SKIP: begin
                    // Edges E1..E(LAT) land here; the stream is not yet valid.
                    if (r_cnt == CW'(LAT - 1)) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                SHIFT: begin
                    r_product <= {bus.serial_in, r_product[W-1:1]};
                    if (r_cnt == CW'(W - 1)) begin
                        r_state <= DONE;
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_product_collector.sv
// Scoreboard bench for mul_product_collector.
// Two instances: n=4/LAT=1 and n=32/LAT=0.
`timescale 1ns/1ps

module tb_mul_product_collector;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mul_product_collector_if #(.n(4))  a_if ();
    mul_product_collector_if #(.n(32)) b_if ();

    mul_product_collector #(.n(4), .LAT(1)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    mul_product_collector #(.n(32), .LAT(0)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  qa[$];
    logic [63:0] qb[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pop and compare on every accepted word.
    always @(negedge clk) begin
        if (rst === 1'b0 && a_if.valid === 1'b1 && a_if.ready === 1'b1) begin
            if (qa.size() == 0)
                chk("a_pop_empty", 64'(qa.size()), 64'd1);
            else
                chk("a_word", 64'(a_if.product), 64'(qa.pop_front()));
        end
        if (rst === 1'b0 && b_if.valid === 1'b1 && b_if.ready === 1'b1) begin
            if (qb.size() == 0)
                chk("b_pop_empty", 64'(qb.size()), 64'd1);
            else
                chk("b_word", b_if.product, qb.pop_front());
        end
    end

    task automatic idle_chk(input string tag);
        chk({tag, "_a_prod"},  64'(a_if.product), 64'd0);
        chk({tag, "_a_valid"}, 64'(a_if.valid),   64'd0);
        chk({tag, "_a_busy"},  64'(a_if.busy),    64'd0);
        chk({tag, "_b_prod"},  b_if.product,      64'd0);
        chk({tag, "_b_valid"}, 64'(b_if.valid),   64'd0);
        chk({tag, "_b_busy"},  64'(b_if.busy),    64'd0);
    endtask

    task automatic collect_a(input logic [7:0] w);
        qa.push_back(w);
        a_if.start = 1'b1;
        tick;
        a_if.start     = 1'b0;
        a_if.serial_in = ~w[0];
        chk("a_busy_start", 64'(a_if.busy),  64'd1);
        chk("a_v_start",    64'(a_if.valid), 64'd0);
        tick;
        for (int i = 0; i < 8; i++) begin
            a_if.serial_in = w[i];
            tick;
            if (i < 7)
                chk("a_early", 64'(a_if.valid), 64'd0);
        end
        chk("a_valid",    64'(a_if.valid), 64'd1);
        chk("a_busy_end", 64'(a_if.busy),  64'd0);
    endtask

    task automatic collect_b(input logic [63:0] w);
        qb.push_back(w);
        b_if.start = 1'b1;
        tick;
        b_if.start = 1'b0;
        chk("b_busy_start", 64'(b_if.busy), 64'd1);
        for (int i = 0; i < 64; i++) begin
            b_if.serial_in = w[i];
            tick;
            if (i < 63)
                chk("b_early", 64'(b_if.valid), 64'd0);
        end
        chk("b_valid",    64'(b_if.valid), 64'd1);
        chk("b_busy_end", 64'(b_if.busy),  64'd0);
    endtask

    initial begin
        rst            = 1'b1;
        a_if.start     = 1'b1;
        a_if.serial_in = 1'b1;
        a_if.ready     = 1'b1;
        b_if.start     = 1'b1;
        b_if.serial_in = 1'b1;
        b_if.ready     = 1'b1;

        // Reset dominates start and data.
        for (int k = 0; k < 2; k++) begin
            tick;
            idle_chk("rst");
        end
        rst        = 1'b0;
        a_if.start = 1'b0;
        b_if.start = 1'b0;
        tick;
        idle_chk("rel");

        // Basic collect.
        collect_a(8'hB4);
        chk("a_prod_b4", 64'(a_if.product), 64'h0B4);
        tick;
        chk("a_v_drop", 64'(a_if.valid),   64'd0);
        chk("a_hold",   64'(a_if.product), 64'h0B4);

        // Ready stall.
        a_if.ready = 1'b0;
        collect_a(8'hB4);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("stall_v", 64'(a_if.valid),   64'd1);
            chk("stall_p", 64'(a_if.product), 64'h0B4);
        end
        a_if.ready = 1'b1;
        tick;
        chk("acc_v", 64'(a_if.valid), 64'd0);
        chk("acc_b", 64'(a_if.busy),  64'd0);

        // Abort after three captures.
        a_if.start = 1'b1;
        tick;
        a_if.start = 1'b0;
        tick;
        for (int i = 0; i < 3; i++) begin
            a_if.serial_in = 1'b1;
            tick;
            chk("abort_v", 64'(a_if.valid), 64'd0);
        end
        collect_a(8'h01);

        // Reset at capture 5 of 8.
        a_if.start = 1'b1;
        tick;
        a_if.start = 1'b0;
        tick;
        for (int i = 0; i < 4; i++) begin
            a_if.serial_in = 1'($urandom);
            tick;
        end
        rst            = 1'b1;
        a_if.serial_in = 1'b1;
        tick;
        chk("mrst_p", 64'(a_if.product), 64'd0);
        chk("mrst_v", 64'(a_if.valid),   64'd0);
        chk("mrst_b", 64'(a_if.busy),    64'd0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick;
            chk("mrst_nov", 64'(a_if.valid), 64'd0);
        end
        collect_a(8'h5A);

        // Start coincides with acceptance.
        collect_a(8'h3C);
        collect_a(8'hC3);
        for (int k = 0; k < 3; k++)
            collect_a(8'($urandom));
        tick;

        // Wide instance, no latency.
        collect_b(64'hFFFF_FFFF_FFFF_FFFF);
        chk("b_ones", b_if.product, 64'hFFFF_FFFF_FFFF_FFFF);
        collect_b({$urandom, $urandom});
        tick;
        tick;

        chk("qa_empty", 64'(qa.size()), 64'd0);
        chk("qb_empty", 64'(qb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
